// File: rtl/framed_stream_parser.sv
// Sync-word framed byte-stream parser: strips header and checksum, forwards the payload
// as an AXI-Stream byte stream, and aborts stalled or oversize frames.
module framed_stream_parser #(
  parameter logic [7:0] SYNC0          = 8'hAA,
  parameter logic [7:0] SYNC1          = 8'h55,
  parameter int         LEN_BYTES      = 1,
  parameter int         MAX_LEN        = 255,
  parameter int         CS_MODE        = 0,
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter int         CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  output logic             m_axis_tuser,
  input  logic             m_axis_tready,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] cnt_good,
  output logic [CNT_W-1:0] cnt_bad_cs,
  output logic [CNT_W-1:0] cnt_abort
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [15:0] MAX_LEN_V = 16'(MAX_LEN);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_PAYLOAD,
    ST_CS,
    ST_FLUSH
  } state_t;

  state_t           state_q;
  logic [7:0]       len_hi_q;
  logic [15:0]      len_q;
  logic [15:0]      byte_cnt_q;
  logic [7:0]       acc_q;
  logic [7:0]       hold_q;
  logic             hold_full_q;
  logic [TMO_W-1:0] tmo_q;
  logic [7:0]       out_data_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic             out_user_q;

  logic        out_free;
  logic        accept;
  logic [15:0] len_now;
  logic        len_over;
  logic [7:0]  acc_next;
  logic        cs_bad;
  logic        tmo_hit;
  logic [2:0]  stat_inc;

  assign out_free      = !out_valid_q || m_axis_tready;
  assign s_axis_tready = (state_q != ST_FLUSH) && out_free;
  assign accept        = s_axis_tvalid && s_axis_tready;

  // With a 1-byte length field len_hi_q stays zero, so one 16-bit path serves both sizes.
  assign len_now  = {len_hi_q, s_axis_tdata};
  assign len_over = len_now > MAX_LEN_V;
  assign acc_next = (CS_MODE == 1) ? acc_q + s_axis_tdata : acc_q ^ s_axis_tdata;
  assign cs_bad   = s_axis_tdata != acc_q;
  assign tmo_hit  = TMO_EN && (state_q != ST_IDLE) && (state_q != ST_FLUSH) &&
                    !accept && (tmo_q == TMO_LAST);

  assign m_axis_tdata  = out_data_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tuser  = out_user_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_hi_q    <= '0;
      len_q       <= '0;
      byte_cnt_q  <= '0;
      acc_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tmo_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_user_q  <= 1'b0;
    end else begin
      if (out_valid_q && m_axis_tready) begin
        out_valid_q <= 1'b0;
      end
      if (state_q == ST_IDLE || state_q == ST_FLUSH || accept) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + TMO_W'(1);
      end

      if (tmo_hit) begin
        state_q <= hold_full_q ? ST_FLUSH : ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (accept && s_axis_tdata == SYNC0) state_q <= ST_SYNC;
          end
          ST_SYNC: begin
            if (accept) begin
              if (s_axis_tdata == SYNC1) begin
                state_q <= (LEN_BYTES == 2) ? ST_LEN_HI : ST_LEN_LO;
              end else if (s_axis_tdata != SYNC0) begin
                state_q <= ST_IDLE;
              end
            end
          end
          ST_LEN_HI: begin
            if (accept) begin
              len_hi_q <= s_axis_tdata;
              state_q  <= ST_LEN_LO;
            end
          end
          ST_LEN_LO: begin
            if (accept) begin
              len_q      <= len_now;
              acc_q      <= '0;
              byte_cnt_q <= '0;
              if (len_over) begin
                state_q <= ST_IDLE;
              end else if (len_now == 16'd0) begin
                state_q <= ST_CS;
              end else begin
                state_q <= ST_PAYLOAD;
              end
            end
          end
          ST_PAYLOAD: begin
            if (accept) begin
              acc_q <= acc_next;
              // One-byte delay lets the final payload byte wait for the checksum verdict.
              if (hold_full_q) begin
                out_data_q  <= hold_q;
                out_valid_q <= 1'b1;
                out_last_q  <= 1'b0;
                out_user_q  <= 1'b0;
              end
              hold_q      <= s_axis_tdata;
              hold_full_q <= 1'b1;
              if (byte_cnt_q == len_q - 16'd1) begin
                state_q <= ST_CS;
              end else begin
                byte_cnt_q <= byte_cnt_q + 16'd1;
              end
            end
          end
          ST_CS: begin
            if (accept) begin
              if (hold_full_q) begin
                out_data_q  <= hold_q;
                out_valid_q <= 1'b1;
                out_last_q  <= 1'b1;
                out_user_q  <= cs_bad;
                hold_full_q <= 1'b0;
              end
              state_q <= ST_IDLE;
            end
          end
          ST_FLUSH: begin
            if (out_free) begin
              out_data_q  <= hold_q;
              out_valid_q <= 1'b1;
              out_last_q  <= 1'b1;
              out_user_q  <= 1'b1;
              hold_full_q <= 1'b0;
              state_q     <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign stat_inc[0] = accept && (state_q == ST_CS) && !cs_bad;
  assign stat_inc[1] = accept && (state_q == ST_CS) && cs_bad;
  assign stat_inc[2] = tmo_hit || (accept && (state_q == ST_LEN_LO) && len_over);

  for (genvar gi = 0; gi < 3; gi++) begin : g_stat
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk) begin
      if (rst || stat_clr) begin
        cnt_q <= '0;
      end else if (stat_inc[gi] && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign cnt_good   = g_stat[0].cnt_q;
  assign cnt_bad_cs = g_stat[1].cnt_q;
  assign cnt_abort  = g_stat[2].cnt_q;

endmodule

// File: tb/tb_framed_stream_parser.sv
// Scoreboard bench for framed_stream_parser: three instances (XOR/1-byte length with short
// timeout, modulo-sum checksum, 2-byte length) driven with directed frames.
module tb_framed_stream_parser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        stat_clr = 1'b0;
  logic [7:0]  s_tdata  [3];
  logic        s_tvalid [3];
  logic        s_tready [3];
  logic [7:0]  m_tdata  [3];
  logic        m_tvalid [3];
  logic        m_tlast  [3];
  logic        m_tuser  [3];
  logic        m_tready [3];
  logic [15:0] c_good   [3];
  logic [15:0] c_bad    [3];
  logic [15:0] c_abort  [3];

  int   tests = 0;
  int   fails = 0;
  logic bp_en = 1'b0;
  logic bp_rdy = 1'b1;

  assign m_tready[0] = bp_rdy;
  assign m_tready[1] = 1'b1;
  assign m_tready[2] = 1'b1;

  always @(posedge clk) begin
    #1;
    bp_rdy = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  framed_stream_parser #(.TIMEOUT_CYCLES(16)) u0 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata[0]), .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]),
    .m_axis_tdata(m_tdata[0]), .m_axis_tvalid(m_tvalid[0]), .m_axis_tlast(m_tlast[0]),
    .m_axis_tuser(m_tuser[0]), .m_axis_tready(m_tready[0]), .stat_clr(stat_clr),
    .cnt_good(c_good[0]), .cnt_bad_cs(c_bad[0]), .cnt_abort(c_abort[0])
  );

  framed_stream_parser #(.CS_MODE(1)) u1 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata[1]), .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]),
    .m_axis_tdata(m_tdata[1]), .m_axis_tvalid(m_tvalid[1]), .m_axis_tlast(m_tlast[1]),
    .m_axis_tuser(m_tuser[1]), .m_axis_tready(m_tready[1]), .stat_clr(stat_clr),
    .cnt_good(c_good[1]), .cnt_bad_cs(c_bad[1]), .cnt_abort(c_abort[1])
  );

  framed_stream_parser #(.LEN_BYTES(2), .MAX_LEN(300)) u2 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata[2]), .s_axis_tvalid(s_tvalid[2]), .s_axis_tready(s_tready[2]),
    .m_axis_tdata(m_tdata[2]), .m_axis_tvalid(m_tvalid[2]), .m_axis_tlast(m_tlast[2]),
    .m_axis_tuser(m_tuser[2]), .m_axis_tready(m_tready[2]), .stat_clr(stat_clr),
    .cnt_good(c_good[2]), .cnt_bad_cs(c_bad[2]), .cnt_abort(c_abort[2])
  );

  // Expected beats per instance, packed as {data, last, user}.
  logic [9:0] q0[$];
  logic [9:0] q1[$];
  logic [9:0] q2[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic l, input logic u);
    case (i)
      0:       q0.push_back({d, l, u});
      1:       q1.push_back({d, l, u});
      default: q2.push_back({d, l, u});
    endcase
  endtask

  function automatic int qsize(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic check_beat(input int i, input logic [9:0] act);
    logic [9:0] e;
    if (qsize(i) == 0) begin
      tests++;
      fails++;
      $display("FAIL beat[%0d]: got unexpected beat {data,last,user}=%h, expected none", i, act);
    end else begin
      case (i)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      $display("beat[%0d] data=%h last=%b user=%b", i, act[9:2], act[1], act[0]);
      chk($sformatf("beat[%0d] {data,last,user}", i), 32'(act), 32'(e));
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (m_tvalid[i] && m_tready[i]) check_beat(i, {m_tdata[i], m_tlast[i], m_tuser[i]});
      end
    end
  end

  task automatic send(input int i, input logic [7:0] b);
    int n;
    n = 0;
    s_tdata[i]  = b;
    s_tvalid[i] = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!s_tready[i] && n < 1000);
    if (!s_tready[i]) chk($sformatf("send[%0d] tready timeout", i), 32'(s_tready[i]), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_bytes(input int i, input int n, input logic [127:0] v);
    for (int k = n - 1; k >= 0; k--) send(i, v[8*k +: 8]);
    s_tvalid[i] = 1'b0;
  endtask

  task automatic exp_beats(input int i, input int n, input logic [127:0] v, input logic u);
    for (int k = n - 1; k >= 0; k--) push(i, v[8*k +: 8], k == 0, (k == 0) ? u : 1'b0);
  endtask

  task automatic drain(input int i);
    int n;
    n = 0;
    while (qsize(i) != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("drain[%0d] beats still missing", i), 32'(qsize(i)), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_cnt(input int i, input int g, input int b, input int a);
    chk($sformatf("cnt_good[%0d]", i), 32'(c_good[i]), 32'(g));
    chk($sformatf("cnt_bad_cs[%0d]", i), 32'(c_bad[i]), 32'(b));
    chk($sformatf("cnt_abort[%0d]", i), 32'(c_abort[i]), 32'(a));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] x;
    logic [7:0] kb;
    for (int i = 0; i < 3; i++) begin
      s_tdata[i]  = 8'h00;
      s_tvalid[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset m_tvalid[%0d]", i), 32'(m_tvalid[i]), 32'd0);
      chk($sformatf("reset m_tdata[%0d]", i), 32'(m_tdata[i]), 32'd0);
      chk($sformatf("reset m_tlast/tuser[%0d]", i), 32'({m_tlast[i], m_tuser[i]}), 32'd0);
      chk($sformatf("reset s_tready[%0d]", i), 32'(s_tready[i]), 32'd1);
      chk_cnt(i, 0, 0, 0);
    end
    @(posedge clk);
    #1;

    // XOR checksum, good then bad
    exp_beats(0, 3, 24'h112233, 1'b0);
    send_bytes(0, 7, 56'hAA5503112233_00);
    drain(0);
    chk_cnt(0, 1, 0, 0);
    exp_beats(0, 3, 24'h112233, 1'b1);
    send_bytes(0, 7, 56'hAA5503112233_01);
    drain(0);
    chk_cnt(0, 1, 1, 0);

    // Resync on repeated SYNC0, then garbage before a frame
    exp_beats(0, 1, 8'h7E, 1'b0);
    send_bytes(0, 6, 48'hAAAA55017E7E);
    drain(0);
    exp_beats(0, 2, 16'hA55A, 1'b0);
    send_bytes(0, 9, 72'h12AA34AA5502A55AFF);
    drain(0);
    chk_cnt(0, 3, 1, 0);

    // Random output backpressure
    bp_en = 1'b1;
    exp_beats(0, 8, 64'h0102030405060708, 1'b0);
    send_bytes(0, 12, 96'hAA5508_0102030405060708_08);
    drain(0);
    bp_en = 1'b0;
    repeat (2) @(negedge clk);
    chk_cnt(0, 4, 1, 0);

    // Inter-byte timeout after payload byte 2 of 4
    push(0, 8'h01, 1'b0, 1'b0);
    push(0, 8'h02, 1'b1, 1'b1);
    send_bytes(0, 5, 40'hAA55040102);
    repeat (14) @(posedge clk);
    @(negedge clk);
    chk("cnt_abort[0] before timeout", 32'(c_abort[0]), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("cnt_abort[0] after timeout", 32'(c_abort[0]), 32'd1);
    drain(0);
    exp_beats(0, 1, 8'h99, 1'b0);
    send_bytes(0, 8, 64'h030405AA55019999);
    drain(0);
    chk_cnt(0, 5, 1, 1);

    // Modulo-256 sum checksum
    exp_beats(1, 3, 24'h112233, 1'b0);
    send_bytes(1, 7, 56'hAA5503112233_66);
    drain(1);
    exp_beats(1, 3, 24'h112233, 1'b1);
    send_bytes(1, 7, 56'hAA5503112233_00);
    drain(1);
    exp_beats(1, 2, 16'hF020, 1'b0);
    send_bytes(1, 6, 48'hAA5502F020_10);
    drain(1);
    chk_cnt(1, 2, 1, 0);

    // Two-byte length: oversize, zero length good/bad, exactly MAX_LEN
    send_bytes(2, 4, 32'hAA55012D);
    repeat (3) @(negedge clk);
    chk_cnt(2, 0, 0, 1);
    send_bytes(2, 5, 40'hAA55000000);
    repeat (3) @(negedge clk);
    chk_cnt(2, 1, 0, 1);
    send_bytes(2, 5, 40'hAA55000001);
    repeat (3) @(negedge clk);
    chk_cnt(2, 1, 1, 1);
    send_bytes(2, 4, 32'hAA55012C);
    x = 8'h00;
    for (int k = 0; k < 300; k++) begin
      kb = k[7:0];
      x = x ^ kb;
      push(2, kb, k == 299, 1'b0);
      send(2, kb);
    end
    send(2, x);
    s_tvalid[2] = 1'b0;
    drain(2);
    chk_cnt(2, 2, 1, 1);

    // Statistics clear, then reset in the middle of a payload
    stat_clr = 1'b1;
    @(posedge clk);
    #1 stat_clr = 1'b0;
    @(negedge clk);
    chk_cnt(0, 0, 0, 0);
    push(0, 8'h10, 1'b0, 1'b0);
    send_bytes(0, 5, 40'hAA55031020);
    drain(0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("m_tvalid[0] after mid-frame reset", 32'(m_tvalid[0]), 32'd0);
    chk_cnt(0, 0, 0, 0);
    @(posedge clk);
    #1;
    exp_beats(0, 2, 16'h0FF0, 1'b0);
    send_bytes(0, 6, 48'hAA55020FF0FF);
    drain(0);
    chk_cnt(0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/framed_stream_parser.md
# framed_stream_parser

Parametrised successor of the byte-stream packet parser. It hunts for a configurable two-byte sync word, reads a 1- or 2-byte length field, forwards the payload as an AXI-Stream byte stream, and validates a trailing checksum (XOR or modulo-256 sum). It also adds full output backpressure, an inter-byte timeout with frame abort, an oversize-length guard and saturating statistics counters. It sits between the byte receiver and the payload consumers in the filter datapath.

## Interface
- SYNC0, 8'hAA: first sync byte
- SYNC1, 8'h55: second sync byte
- LEN_BYTES, 1: length field size, 1 or 2 bytes; 2 = big-endian (MSB first)
- MAX_LEN, 255: largest accepted payload length; 1..(2^(8*LEN_BYTES))-1
- CS_MODE, 0: 0 = XOR of payload bytes; 1 = 8-bit sum of payload bytes mod 256
- TIMEOUT_CYCLES, 1024: idle cycles allowed between accepted beats inside a frame; 0 disables
- CNT_W, 16: statistics counter width
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_axis_tdata  in  8  input byte
- s_axis_tvalid  in  1  input byte valid
- s_axis_tready  out  1  equals !m_axis_tvalid || m_axis_tready; forced 0 in FLUSH
- m_axis_tdata  out  8  payload byte
- m_axis_tvalid  out  1  output valid; held until accepted
- m_axis_tlast  out  1  last payload byte of frame
- m_axis_tuser  out  1  qualified by tlast: 1 = checksum mismatch or aborted frame
- stat_clr  in  1  synchronous clear of all counters
- cnt_good  out  CNT_W  frames with matching checksum; saturating
- cnt_bad_cs  out  CNT_W  frames with checksum mismatch; saturating
- cnt_abort  out  CNT_W  timeouts plus oversize lengths; saturating

## Operation
- Frame format: SYNC0, SYNC1, LEN (LEN_BYTES bytes), LEN payload bytes, CS byte.
- Beat accepted means s_axis_tvalid && s_axis_tready. The FSM advances only on accepted beats, except on timeout.
- IDLE: SYNC0 goes to SYNC. All other bytes are discarded.
- SYNC: SYNC1 goes to LEN_HI (LEN_BYTES=2) or LEN_LO. SYNC0 stays in SYNC. Any other byte returns to IDLE.
- LEN_HI: latch the high byte, go to LEN_LO.
- LEN_LO: form len and clear the checksum accumulator and byte counter.
  - len > MAX_LEN: increment cnt_abort, go to IDLE.
  - len == 0: go to CS.
  - Otherwise: go to PAYLOAD.
- PAYLOAD:
  - Each byte updates the accumulator (XOR or sum per CS_MODE) and is written to a 1-byte hold register.
  - If the hold register was already full, its previous content is loaded into the output register (tlast=0).
  - After len bytes, go to CS.
- CS: compare the received byte against the accumulator.
  - If len > 0: load the held byte into the output register with tlast=1, tuser=mismatch.
  - If len == 0: no output beat; good when CS == 8'h00.
  - Increment cnt_good or cnt_bad_cs, go to IDLE.
- Timeout: while not IDLE, a counter increments each cycle without an accepted beat and clears on every accepted beat.
  - When it reaches TIMEOUT_CYCLES: increment cnt_abort.
  - If the hold register is full, go to FLUSH; otherwise go to IDLE.
- FLUSH: s_axis_tready=0. Once the output register is free, emit the held byte with tlast=1, tuser=1, then go to IDLE.
- Counters saturate at all-ones.
- stat_clr has priority over a simultaneous increment; the counter reads 0 next cycle.

## Timing
- Reset: state IDLE, hold register empty, accumulator, timeout counter and all counters 0.
- Outputs after reset: m_axis_tdata=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, s_axis_tready=1.
- Reset mid-frame drops the frame silently. No tlast is emitted and no counter changes.
- Payload byte k (k < len-1) is presented the cycle after payload byte k+1 is accepted.
- The last payload byte is presented the cycle after CS is accepted.
- The output register holds tdata, tvalid, tlast and tuser stable until tready.
- Simultaneous output accept and new input beat in the same cycle is legal; throughput is 1 byte/cycle.
- Counter increment is visible the cycle after the CS beat or abort event.

## Test plan
- Default params, bytes AA 55 03 11 22 33 00 (XOR=00) with tready=1: outputs 11, 22, 33; tlast and tuser=0 on 33; cnt_good=1.
- Same frame with CS=01: 33 carries tlast=1, tuser=1; cnt_bad_cs=1. Repeat with CS_MODE=1 and CS=66: good.
- Resync: AA AA 55 01 7E 7E: one byte 7E, tlast, tuser=0.
- Garbage 12 AA 34 before a valid frame: garbage is ignored and the frame parses normally.
- LEN_BYTES=2, MAX_LEN=300, length 01 2D (301): cnt_abort=1, no output beats. Length 00 00 followed by CS 00: cnt_good=1, no output beats.
- Backpressure: random m_axis_tready at 50% duty gives an identical output sequence with no beat dropped or duplicated.
- Timeout: TIMEOUT_CYCLES=16, input stalls after payload byte 2 of 4.
  - On the 16th idle cycle, byte 2 is emitted with tlast=1, tuser=1 and cnt_abort=1.
  - Subsequent bytes are parsed from IDLE.
- rst asserted mid-payload: no tlast, counters unchanged, next frame parses correctly.
